// File: rtl/tdm_ws_ctrl.sv
// tdm_ws_ctrl: TDM frame controller that generates (master) or tracks (slave) word select
// and maintains slot/bit counters; all state advances on the falling edge of the bit clock.
module tdm_ws_ctrl #(
    parameter int MAX_SLOTS = 8,
    parameter int MAX_BITS  = 32
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         master,
    input  logic                         en,
    input  logic                         ready,
    input  logic                         stop,
    input  logic [1:0]                   fmt,
    input  logic [$clog2(MAX_SLOTS)-1:0] slots_m1,
    input  logic [$clog2(MAX_BITS)-1:0]  bits_m1,
    input  logic                         ws_in,
    output logic                         ws_out,
    output logic                         active,
    output logic [$clog2(MAX_SLOTS)-1:0] slot_idx,
    output logic [$clog2(MAX_BITS)-1:0]  bit_idx,
    output logic                         slot_req,
    output logic                         frame_start,
    output logic                         sync_err,
    output logic                         cfg_err
);
    localparam int SW = $clog2(MAX_SLOTS);
    localparam int BW = $clog2(MAX_BITS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state, state_n;
    logic          mode, mst, ws_d, latch, ws_n;
    logic [1:0]    sh_fmt, cur_fmt, nx_fmt;
    logic [SW-1:0] sh_slots, nx_slots, slot_n;
    logic [BW-1:0] sh_bits, bit_n;
    logic [SW:0]   half, nx_half;
    logic          bad_in, start, slot_end, fend, lvl_err;

    assign active      = state == ACTIVE;
    assign mst         = active ? mode : master;
    assign bad_in      = fmt == 2'd3 || (!fmt[1] && !slots_m1[0]);
    assign cfg_err     = !active && bad_in;
    assign cur_fmt     = active ? sh_fmt : fmt;
    assign start       = !stop && (cur_fmt == 2'd0 ? ws_d && !ws_in : !ws_d && ws_in);
    assign slot_end    = bit_idx == sh_bits;
    assign fend        = active && slot_end && slot_idx == sh_slots;
    assign half        = ({1'b0, sh_slots} + 1'b1) >> 1;
    // Slave expects the second-half level on the first bit of slot S/2 in I2S/MSB.
    assign lvl_err     = !sh_fmt[1] && {1'b0, slot_idx} == half && bit_idx == '0 &&
                         ws_in != (sh_fmt == 2'd0);
    assign slot_req    = active && !stop && bit_idx == '0;
    assign frame_start = slot_req && slot_idx == '0;
    assign sync_err    = active && !stop && !mst && ((start && !fend) || lvl_err);

    always_comb begin
        state_n = state;
        slot_n  = slot_idx;
        bit_n   = bit_idx;
        latch   = 1'b0;
        if (!stop) begin
            if (!active) begin
                if (!bad_in && (mst ? en && ready : start)) begin
                    state_n = ACTIVE;
                    slot_n  = '0;
                    bit_n   = '0;
                    latch   = 1'b1;
                end
            end else if (fend) begin
                latch   = 1'b1;
                slot_n  = '0;
                bit_n   = '0;
                state_n = (!bad_in && (mst ? en && ready : start)) ? ACTIVE : IDLE;
            end else if (!mst && start) begin
                slot_n = '0;
                bit_n  = '0;
            end else if (slot_end) begin
                slot_n = slot_idx + 1'b1;
                bit_n  = '0;
            end else begin
                bit_n = bit_idx + 1'b1;
            end
        end
    end

    // ws_out is registered, so it is derived from the counters and format of the next cycle.
    assign nx_fmt   = latch ? fmt : sh_fmt;
    assign nx_slots = latch ? slots_m1 : sh_slots;
    assign nx_half  = ({1'b0, nx_slots} + 1'b1) >> 1;

    always_comb begin
        ws_n = fmt == 2'd0;
        if (stop)
            ws_n = ws_out;
        else if (mst && state_n == ACTIVE)
            ws_n = nx_fmt == 2'd2 ? (slot_n == '0 && bit_n == '0)
                                  : (({1'b0, slot_n} >= nx_half) ^ nx_fmt[0]);
    end

    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            mode     <= 1'b0;
            slot_idx <= '0;
            bit_idx  <= '0;
            ws_out   <= 1'b0;
            ws_d     <= 1'b0;
            sh_fmt   <= 2'd0;
            sh_slots <= SW'(1);
            sh_bits  <= '1;
        end else begin
            state    <= state_n;
            mode     <= mst;
            slot_idx <= slot_n;
            bit_idx  <= bit_n;
            ws_out   <= ws_n;
            ws_d     <= ws_in;
            if (latch) begin
                sh_fmt   <= fmt;
                sh_slots <= slots_m1;
                sh_bits  <= bits_m1;
            end
        end
    end
endmodule
